// File: rtl/pipe_pkg.sv
// Shared constants for the reusable pipeline stage register: per-stage bundle widths,
// control-bundle bit positions and the skid FSM encoding ({skid_valid, main_valid}).
package pipe_pkg;

  localparam int unsigned ID_EX_DATA_W  = 275;
  localparam int unsigned ID_EX_CTRL_W  = 9;
  localparam int unsigned EX_MEM_DATA_W = 197;
  localparam int unsigned EX_MEM_CTRL_W = 5;
  localparam int unsigned MEM_WB_DATA_W = 133;
  localparam int unsigned MEM_WB_CTRL_W = 2;

  localparam int unsigned ALUOP_LSB    = 0;
  localparam int unsigned ALUOP_W      = 2;
  localparam int unsigned ALUSRC_BIT   = 2;
  localparam int unsigned BRANCHEQ_BIT = 3;
  localparam int unsigned BRANCHGT_BIT = 4;
  localparam int unsigned MEMREAD_BIT  = 5;
  localparam int unsigned MEMWRITE_BIT = 6;
  localparam int unsigned REGWRITE_BIT = 7;
  localparam int unsigned MEMTOREG_BIT = 8;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and bundle signals of one pipeline stage register; slave is the stage itself,
// master is whatever drives it (upstream producer plus downstream consumer).
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = ID_EX_DATA_W,
  parameter int unsigned CTRL_W = ID_EX_CTRL_W,
  parameter int unsigned CNT_W  = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );

  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );

endinterface

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the stage register: owns in_ready and the load/clear enables that
// steer the main and skid datapath registers in pipe_stage_reg.
module pipe_skid_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned SKID = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_in_valid,
  input  logic i_out_ready,
  input  logic i_flush,
  output logic o_in_ready,
  output logic o_main_valid,
  output logic o_load_main_in,
  output logic o_load_main_skid,
  output logic o_load_skid,
  output logic o_clr_main_ctrl,
  output logic o_clr_skid_ctrl
);

  logic [1:0] r_state;
  logic [1:0] w_state_d;
  logic       r_in_ready;
  logic       w_in_ready_comb;
  logic       w_accept;
  logic       w_fire;

  assign o_main_valid    = r_state[0];
  assign w_fire          = r_state[0] & i_out_ready;
  assign w_in_ready_comb = i_out_ready | ~r_state[0];
  assign o_in_ready      = (SKID != 0) ? r_in_ready : w_in_ready_comb;
  assign w_accept        = i_in_valid & o_in_ready;

  always_comb begin
    w_state_d        = r_state;
    o_load_main_in   = 1'b0;
    o_load_main_skid = 1'b0;
    o_load_skid      = 1'b0;
    o_clr_main_ctrl  = 1'b0;
    o_clr_skid_ctrl  = 1'b0;
    if (i_flush) begin
      // A same-cycle accept is dropped: no load enable is raised here.
      w_state_d       = ST_EMPTY;
      o_clr_main_ctrl = 1'b1;
      o_clr_skid_ctrl = 1'b1;
    end else if (SKID == 0) begin
      if (w_accept) begin
        w_state_d      = ST_ONE;
        o_load_main_in = 1'b1;
      end else if (w_fire) begin
        w_state_d       = ST_EMPTY;
        o_clr_main_ctrl = 1'b1;
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_d      = ST_ONE;
            o_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_fire) begin
            o_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_d   = ST_FULL;
            o_load_skid = 1'b1;
          end else if (w_fire) begin
            w_state_d       = ST_EMPTY;
            o_clr_main_ctrl = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_fire) begin
            w_state_d        = ST_ONE;
            o_load_main_skid = 1'b1;
            o_clr_skid_ctrl  = 1'b1;
          end
        end
        default: w_state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_in_ready <= (w_state_d != ST_FULL);
    end
  end

  a_full_not_ready: assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_FULL) |-> !o_in_ready);

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready handshake, optional 2-entry skid buffer,
// flush with bubble insertion (ctrl forced to 0 when invalid) and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = ID_EX_DATA_W,
  parameter int unsigned CTRL_W = ID_EX_CTRL_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  logic              w_in_ready;
  logic              w_main_valid;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic              w_clr_main_ctrl;
  logic              w_clr_skid_ctrl;
  logic              w_fire;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  pipe_skid_ctrl #(
    .SKID (SKID)
  ) u_ctrl (
    .clk              (clk),
    .reset            (reset),
    .i_in_valid       (bus.in_valid),
    .i_out_ready      (bus.out_ready),
    .i_flush          (bus.flush),
    .o_in_ready       (w_in_ready),
    .o_main_valid     (w_main_valid),
    .o_load_main_in   (w_load_main_in),
    .o_load_main_skid (w_load_main_skid),
    .o_load_skid      (w_load_skid),
    .o_clr_main_ctrl  (w_clr_main_ctrl),
    .o_clr_skid_ctrl  (w_clr_skid_ctrl)
  );

  assign w_fire        = w_main_valid & bus.out_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_main_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_ctrl  = r_main_ctrl;
  assign bus.stall_cnt = r_stall_cnt;

  // Data is never cleared on bubble/flush; only ctrl carries the kill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_data <= bus.in_data;
        r_main_ctrl <= bus.in_ctrl;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end else if (w_clr_main_ctrl) begin
        r_main_ctrl <= '0;
      end
      if (w_load_skid) begin
        r_skid_data <= bus.in_data;
        r_skid_ctrl <= bus.in_ctrl;
      end else if (w_clr_skid_ctrl) begin
        r_skid_ctrl <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (w_main_valid && !bus.out_ready && !bus.flush) |=>
      ($stable(r_main_data) && $stable(r_main_ctrl)));

  a_no_accept_blocked: assert property (@(posedge clk) disable iff (reset)
    (!w_in_ready && !w_fire) |=> ($stable(r_main_data) && $stable(r_skid_data)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 ID/EX-width instance and a SKID=0 CNT_W=4 instance,
// each compared every cycle against a queue model, plus hand-computed literal checks.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned AD = ID_EX_DATA_W;
  localparam int unsigned AC = ID_EX_CTRL_W;
  localparam int unsigned BD = 16;
  localparam int unsigned BC = 9;
  localparam int unsigned BN = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(AD), .CTRL_W(AC), .CNT_W(16)) ifa ();
  pipe_stage_reg_if #(.DATA_W(BD), .CTRL_W(BC), .CNT_W(BN)) ifb ();

  pipe_stage_reg #(.DATA_W(AD), .CTRL_W(AC), .SKID(1), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  pipe_stage_reg #(.DATA_W(BD), .CTRL_W(BC), .SKID(0), .CNT_W(BN)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  task automatic chk(input string name, input logic [AD-1:0] act, input logic [AD-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  logic [AD-1:0] qa_d[$];
  logic [AC-1:0] qa_c[$];
  logic [BD-1:0] qb_d[$];
  logic [BC-1:0] qb_c[$];
  int unsigned   sa = 0;
  int unsigned   sb = 0;
  bit            acc_a, fir_a, acc_b, fir_b;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qa_d.delete(); qa_c.delete(); qb_d.delete(); qb_c.delete();
      sa = 0;
      sb = 0;
    end else begin
      fir_a = (qa_d.size() > 0) && ifa.out_ready;
      acc_a = ifa.in_valid && (qa_d.size() < 2);
      if ((qa_d.size() > 0) && !ifa.out_ready && (sa < 65535)) sa++;
      if (ifa.flush) begin
        qa_d.delete(); qa_c.delete();
      end else begin
        if (fir_a) begin
          void'(qa_d.pop_front());
          void'(qa_c.pop_front());
        end
        if (acc_a) begin
          qa_d.push_back(ifa.in_data);
          qa_c.push_back(ifa.in_ctrl);
        end
      end
      fir_b = (qb_d.size() > 0) && ifb.out_ready;
      acc_b = ifb.in_valid && (ifb.out_ready || (qb_d.size() == 0));
      if ((qb_d.size() > 0) && !ifb.out_ready && (sb < 15)) sb++;
      if (ifb.flush) begin
        qb_d.delete(); qb_c.delete();
      end else begin
        if (fir_b) begin
          void'(qb_d.pop_front());
          void'(qb_c.pop_front());
        end
        if (acc_b) begin
          qb_d.push_back(ifb.in_data);
          qb_c.push_back(ifb.in_ctrl);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("a_in_ready", AD'(ifa.in_ready), AD'(qa_d.size() < 2));
    chk("a_out_valid", AD'(ifa.out_valid), AD'(qa_d.size() > 0));
    chk("a_out_ctrl", AD'(ifa.out_ctrl), AD'((qa_d.size() > 0) ? qa_c[0] : AC'(0)));
    if (qa_d.size() > 0) chk("a_out_data", ifa.out_data, qa_d[0]);
    chk("a_stall_cnt", AD'(ifa.stall_cnt), AD'(sa));
    chk("b_in_ready", AD'(ifb.in_ready), AD'(ifb.out_ready || (qb_d.size() == 0)));
    chk("b_out_valid", AD'(ifb.out_valid), AD'(qb_d.size() > 0));
    chk("b_out_ctrl", AD'(ifb.out_ctrl), AD'((qb_d.size() > 0) ? qb_c[0] : BC'(0)));
    if (qb_d.size() > 0) chk("b_out_data", AD'(ifb.out_data), AD'(qb_d[0]));
    chk("b_stall_cnt", AD'(ifb.stall_cnt), AD'(sb));
  end

  initial begin
    reset         = 1'b1;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = AD'(5);
    ifa.in_ctrl   = AC'(9'h1FF);
    ifa.flush     = 1'b0;
    ifa.out_ready = 1'b0;
    ifb.in_valid  = 1'b1;
    ifb.in_data   = BD'(5);
    ifb.in_ctrl   = BC'(9'h1FF);
    ifb.flush     = 1'b0;
    ifb.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_out_valid", AD'(ifa.out_valid), AD'(0));
    chk("rst_a_out_ctrl", AD'(ifa.out_ctrl), AD'(0));
    chk("rst_a_in_ready", AD'(ifa.in_ready), AD'(1));
    chk("rst_a_stall", AD'(ifa.stall_cnt), AD'(0));
    chk("rst_b_out_ctrl", AD'(ifb.out_ctrl), AD'(0));
    @(negedge clk);
    reset        = 1'b0;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;

    // Streaming with downstream always ready
    ifa.out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = AD'(i);
      ifa.in_ctrl  = AC'(i) | AC'(1 << REGWRITE_BIT);
      tick();
      chk("stream_data", ifa.out_data, AD'(i));
      chk("stream_ready", AD'(ifa.in_ready), AD'(1));
    end
    ifa.in_valid = 1'b0;
    tick();
    chk("drain_valid", AD'(ifa.out_valid), AD'(0));
    chk("drain_ctrl", AD'(ifa.out_ctrl), AD'(0));

    // Backpressure fills main then skid
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = AD'(12'hAAA);
    ifa.in_ctrl   = AC'(9'h0A3);
    tick();
    chk("bp_a_data", ifa.out_data, AD'(12'hAAA));
    ifa.in_data = AD'(12'hBBB);
    ifa.in_ctrl = AC'(9'h0B5);
    tick();
    chk("bp_full_ready", AD'(ifa.in_ready), AD'(0));
    chk("bp_hold_a", ifa.out_data, AD'(12'hAAA));
    chk("bp_stall1", AD'(ifa.stall_cnt), AD'(1));
    ifa.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_stall3", AD'(ifa.stall_cnt), AD'(3));
    ifa.out_ready = 1'b1;
    tick();
    chk("bp_b_data", ifa.out_data, AD'(12'hBBB));
    chk("bp_b_ctrl", AD'(ifa.out_ctrl), AD'(9'h0B5));
    chk("bp_ready_back", AD'(ifa.in_ready), AD'(1));
    tick();
    chk("bp_empty", AD'(ifa.out_valid), AD'(0));

    // Flush while full with a simultaneous accept attempt
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = AD'(12'hCCC);
    ifa.in_ctrl   = AC'(9'h0C1);
    tick();
    ifa.in_data = AD'(12'hDDD);
    ifa.in_ctrl = AC'(9'h0D2);
    tick();
    chk("fl_full", AD'(ifa.in_ready), AD'(0));
    ifa.in_data = AD'(12'hEEE);
    ifa.in_ctrl = AC'(9'h0E4);
    ifa.flush   = 1'b1;
    tick();
    chk("fl_valid", AD'(ifa.out_valid), AD'(0));
    chk("fl_ctrl", AD'(ifa.out_ctrl), AD'(0));
    chk("fl_ready", AD'(ifa.in_ready), AD'(1));
    chk("fl_data_kept", ifa.out_data, AD'(12'hCCC));
    chk("fl_stall_kept", AD'(ifa.stall_cnt), AD'(5));
    ifa.flush     = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    repeat (3) tick();
    chk("fl_nothing_out", AD'(ifa.out_valid), AD'(0));

    // Stall counter saturation on the 4-bit, no-skid instance
    ifb.in_valid = 1'b1;
    ifb.in_data  = BD'(16'h0055);
    ifb.in_ctrl  = BC'(9'h0F0);
    tick();
    ifb.in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_stall", AD'(ifb.stall_cnt), AD'(15));
    chk("sat_data", AD'(ifb.out_data), AD'(16'h0055));
    ifb.out_ready = 1'b1;
    #1;
    chk("comb_ready_hi", AD'(ifb.in_ready), AD'(1));
    ifb.out_ready = 1'b0;
    #1;
    chk("comb_ready_lo", AD'(ifb.in_ready), AD'(0));

    // Alternating downstream readiness, no skid
    for (int i = 0; i < 24; i++) begin
      ifb.out_ready = (i % 2 == 1);
      ifb.in_valid  = (i % 3 != 2);
      ifb.in_data   = BD'(16'h0100 + i);
      ifb.in_ctrl   = BC'(9'h100) | BC'(i);
      tick();
    end
    ifb.in_valid  = 1'b0;
    ifb.out_ready = 1'b1;
    repeat (3) tick();
    chk("alt_drained", AD'(ifb.out_valid), AD'(0));
    chk("alt_stall_sat", AD'(ifb.stall_cnt), AD'(15));

    // Asynchronous reset in the middle of a cycle
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = AD'(12'hFFF);
    ifa.in_ctrl   = AC'(9'h1FF);
    tick();
    ifa.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", AD'(ifa.out_valid), AD'(0));
    chk("arst_ctrl", AD'(ifa.out_ctrl), AD'(0));
    chk("arst_data", ifa.out_data, AD'(0));
    chk("arst_stall", AD'(ifa.stall_cnt), AD'(0));
    chk("arst_b_stall", AD'(ifb.stall_cnt), AD'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register replacing the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Carries a data bundle and a separate control bundle.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, flush with bubble insertion, and a saturating stall counter.
- Sits between any two pipeline stages; the ID/EX instance uses the default widths.

Parameters:
DATA_W, 275, data bundle width (ID/EX: instr 4 + rd/rs1/rs2 15 + ReadData1/ReadData2/imm/PC 4x64).
CTRL_W, 9, control bundle width (ALUOp 2, ALUSrc, BranchEq, BranchGt, MemRead, MemWrite, RegWrite, MemtoReg); zeroed on bubble.
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  upstream has a bundle.
in_ready  out  1  stage can accept.
in_data  in  DATA_W  upstream data bundle.
in_ctrl  in  CTRL_W  upstream control bundle.
flush  in  1  kill all held entries (branch taken / hazard).
out_valid  out  1  output bundle valid.
out_ready  in  1  downstream accepts.
out_data  out  DATA_W  held data bundle.
out_ctrl  out  CTRL_W  held control bundle; 0 whenever out_valid=0.
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- One clock `clk`; reset `reset` is asynchronous, active-high. All state uses nonblocking assignment on posedge clk or posedge reset.
- Reset values:
  - out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - Skid entry invalid, skid data/ctrl 0.
  - in_ready=1 (SKID=1); with SKID=0, in_ready follows its combinational equation.
- Handshakes: accept = in_valid & in_ready; fire = out_valid & out_ready. in_data/in_ctrl are ignored when in_valid=0.
- Latency: accepted bundle appears at out_* the cycle after accept when the stage was empty.
- SKID=1 FSM (state = {skid_valid, main_valid}); in_ready is registered = (state != FULL):
  - EMPTY: accept -> ONE, main<=in. Otherwise stay.
  - ONE:
    - accept & fire -> ONE, main<=in.
    - accept & !fire -> FULL, skid<=in, main held.
    - !accept & fire -> EMPTY, main ctrl<=0.
    - Otherwise hold.
  - FULL: fire -> ONE, main<=skid, skid ctrl<=0. Otherwise hold. in_ready=0.
  - Ordering is strictly FIFO: the skid entry never overtakes main.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - accept -> main<=in, out_valid<=1.
  - fire without accept -> out_valid<=0, out_ctrl<=0.
- Flush (highest priority after reset):
  - Next state EMPTY; out_valid<=0; out_ctrl<=0; skid ctrl<=0.
  - Any accept in the same cycle is discarded.
  - out_data keeps its last value.
  - in_ready is 1 the following cycle.
- Bubble guarantee: out_ctrl==0 in every cycle where out_valid==0, including after fire-empty and after flush. Downstream never sees RegWrite/MemWrite from an invalid slot.
- stall_cnt:
  - +1 each cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by reset; unaffected by flush.
- Reset mid-operation clears everything immediately, independent of clk.
- Assertions: stable out_data/out_ctrl while out_valid & ~out_ready; no accept when in_ready=0.

Decomposition:
- Shared package pipe_pkg:
  - Width constants: ID_EX_DATA_W=275, ID_EX_CTRL_W=9, EX_MEM_*/MEM_WB_* widths.
  - Control-bundle bit-index constants: ALUOP_LSB, ALUSRC_BIT, BRANCHEQ_BIT, BRANCHGT_BIT, MEMREAD_BIT, MEMWRITE_BIT, REGWRITE_BIT, MEMTOREG_BIT.
  - FSM state encoding: EMPTY, ONE, FULL.
- Natural sub-module: pipe_skid_ctrl, holding the FSM, in_ready register and load/select enables; the datapath registers stay in pipe_stage_reg.

Test Plan:
1. Reset with in_valid=1, in_ctrl=9'h1FF -> out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0 until the first posedge after reset falls.
2. Streaming: out_ready=1, in_valid=1, data 1,2,3,... -> out_data 1,2,3 with 1-cycle latency; in_ready stays 1; stall_cnt stays 0.
3. Backpressure (SKID=1): send A, B while out_ready=0 -> in_ready=0 after B; out_data=A held; stall_cnt increments each cycle. Raise out_ready -> A then B out, in_ready back to 1.
4. Flush in FULL state with simultaneous accept attempt -> next cycle out_valid=0, out_ctrl=0, in_ready=1; neither A, B, nor the new input ever appears.
5. Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt reaches 15 and holds.
6. SKID=0 with alternating out_ready -> in_ready tracks out_ready | ~out_valid combinationally; no bundle lost or duplicated (scoreboard compare).
